// File: rtl/multicycle_ctrl.sv
// Multicycle datapath control unit: fetch/decode/execute/memory/write-back
// sequencer with ADDI, illegal-opcode trap, memory wait states and a retire pulse.
module multicycle_ctrl #(
  parameter int              OP_W        = 6,
  parameter logic [OP_W-1:0] OP_RTYPE    = 0,
  parameter logic [OP_W-1:0] OP_BEQ      = 1,
  parameter logic [OP_W-1:0] OP_J        = 2,
  parameter logic [OP_W-1:0] OP_LW       = 3,
  parameter logic [OP_W-1:0] OP_SW       = 4,
  parameter logic [OP_W-1:0] OP_ADDI     = 5,
  parameter bit              MEM_WAIT_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rset,
  input  logic [OP_W-1:0] op,
  input  logic            mem_ready,
  output logic            PCWriteCond,
  output logic            PCwrite,
  output logic            IorD,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            MemtoReg,
  output logic            IRwrite,
  output logic            ALUsrcA,
  output logic            Regwrite,
  output logic            RegDst,
  output logic [1:0]      ALUsrcB,
  output logic [1:0]      ALUOp,
  output logic [1:0]      PCsource,
  output logic            illegal_op,
  output logic            instr_done,
  output logic [3:0]      state
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEMADD   = 4'd3,
    MEMRD    = 4'd4,
    MEMWB    = 4'd5,
    MEMWR    = 4'd6,
    RTYPE_EX = 4'd7,
    RTYPE_WB = 4'd8,
    ADDI_EX  = 4'd9,
    ADDI_WB  = 4'd10,
    BRANCH   = 4'd11,
    JUMP     = 4'd12
  } state_t;

  localparam logic [1:0] CLS_NONE = 2'd0;
  localparam logic [1:0] CLS_LW   = 2'd1;
  localparam logic [1:0] CLS_SW   = 2'd2;

  state_t     state_q, state_d;
  logic [1:0] cls_q, cls_d;
  logic       illegal_q, illegal_d;
  logic       acc;
  logic       op_legal;

  assign acc      = !MEM_WAIT_EN || mem_ready;
  assign op_legal = (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW) ||
                    (op == OP_SW) || (op == OP_BEQ) || (op == OP_J);

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE:   state_d = FETCH;
      FETCH:  if (acc) state_d = DECODE;
      DECODE: begin
        // Priority order matters only if two opcode parameters collide.
        if (op == OP_RTYPE)     state_d = RTYPE_EX;
        else if (op == OP_ADDI) state_d = ADDI_EX;
        else if (op == OP_LW) begin
          state_d = MEMADD;
          cls_d   = CLS_LW;
        end else if (op == OP_SW) begin
          state_d = MEMADD;
          cls_d   = CLS_SW;
        end else if (op == OP_BEQ) state_d = BRANCH;
        else if (op == OP_J)       state_d = JUMP;
        else begin
          state_d   = FETCH;
          illegal_d = 1'b1;
        end
      end
      // op may have changed by now; the class register decides LW vs SW.
      MEMADD:   state_d = (cls_q == CLS_LW) ? MEMRD :
                          (cls_q == CLS_SW) ? MEMWR : FETCH;
      MEMRD:    if (acc) state_d = MEMWB;
      MEMWR:    if (acc) state_d = FETCH;
      RTYPE_EX: state_d = RTYPE_WB;
      ADDI_EX:  state_d = ADDI_WB;
      MEMWB, RTYPE_WB, ADDI_WB, BRANCH, JUMP: state_d = FETCH;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rset) begin
    if (!rset) begin
      state_q   <= IDLE;
      cls_q     <= CLS_NONE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    PCWriteCond = 1'b0;
    PCwrite     = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRwrite     = 1'b0;
    ALUsrcA     = 1'b0;
    Regwrite    = 1'b0;
    RegDst      = 1'b0;
    ALUsrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCsource    = 2'b00;
    instr_done  = 1'b0;
    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        ALUsrcB = 2'b01;
        PCwrite = acc;
        IRwrite = acc;
      end
      DECODE: begin
        ALUsrcB    = 2'b11;
        instr_done = !op_legal;
      end
      MEMADD, ADDI_EX: begin
        ALUsrcA = 1'b1;
        ALUsrcB = 2'b10;
      end
      MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      MEMWB: begin
        Regwrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      MEMWR: begin
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        instr_done = acc;
      end
      RTYPE_EX: begin
        ALUsrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      RTYPE_WB: begin
        Regwrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
      end
      ADDI_WB: begin
        Regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        ALUsrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCsource    = 2'b01;
        instr_done  = 1'b1;
      end
      JUMP: begin
        PCwrite    = 1'b1;
        PCsource   = 2'b10;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal_op = illegal_q;
  assign state      = state_q;

endmodule
